// File: rtl/tt_um_seven_segment_fun1_pkg.sv
// tt_um_seven_segment_fun1_pkg: hex segment table, segment bit indices and mode encoding
package tt_um_seven_segment_fun1_pkg;
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  typedef enum logic {MODE_DIGIT = 1'b0, MODE_ANIM = 1'b1} mode_t;
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  function automatic logic [6:0] hex_seg(input logic [3:0] d);
    return HEX_SEG[d];
  endfunction
endpackage

// File: rtl/tt_um_seven_segment_fun1_debounce.sv
// tt_um_seven_segment_fun1_debounce: 2-flop synchronizer + level debouncer emitting a one-cycle press pulse (clk, rst active-high sync, din async button, press)
module tt_um_seven_segment_fun1_debounce #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic press
);
  localparam int CW = DEBOUNCE_CYCLES > 2 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 2);
  logic s1, s2, level;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      level <= 1'b0;
      cnt <= '0;
      press <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      press <= 1'b0;
      if (s2 == level) cnt <= '0;
      else if (cnt == LAST) begin
        cnt <= '0;
        level <= ~level;
        press <= ~level;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/tt_um_seven_segment_fun1.sv
// tt_um_seven_segment_fun1: debounced hex counter on a 7-segment display with optional spinning animation (SEVSEG_ANIM_EN); clk, rst_n (active-high sync), ui_in buttons, uo_out segments+mode, uio_* unused
module tt_um_seven_segment_fun1
  import tt_um_seven_segment_fun1_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int ANIM_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  logic [3:0] press;
  logic [3:0] digit;
  logic [6:0] seg;
  mode_t mode;
  genvar i;
  for (i = 0; i < 4; i++) begin : g_db
    tt_um_seven_segment_fun1_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk),
      .rst(rst_n),
      .din(ui_in[i]),
      .press(press[i])
    );
  end
  always_ff @(posedge clk) begin
    if (rst_n) digit <= 4'h0;
    else if (press[3]) digit <= 4'h0;
    else if (press[0]) digit <= digit + 4'h1;
    else if (press[1]) digit <= digit - 4'h1;
  end
`ifdef SEVSEG_ANIM_EN
  localparam int TW = ANIM_CYCLES > 1 ? $clog2(ANIM_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'(ANIM_CYCLES - 1);
  logic [TW-1:0] tmr;
  logic [2:0] pos;
  always_ff @(posedge clk) begin
    if (rst_n) begin
      mode <= MODE_DIGIT;
      tmr <= '0;
      pos <= 3'(SEG_A);
    end else if (press[2]) begin
      mode <= mode_t'(~mode);
      tmr <= '0;
      pos <= 3'(SEG_A);
    end else if (mode == MODE_ANIM) begin
      if (tmr == TLAST) begin
        tmr <= '0;
        pos <= pos == 3'(SEG_F) ? 3'(SEG_A) : pos + 3'd1;
      end else tmr <= tmr + 1'b1;
    end
  end
  assign seg = mode == MODE_ANIM ? 7'd1 << pos : hex_seg(digit);
  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:4]};
`else
  assign mode = MODE_DIGIT;
  assign seg = hex_seg(digit);
  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:4], press[2]};
`endif
  assign uo_out = {mode == MODE_ANIM, seg};
  assign uio_out = 8'h00;
  assign uio_oe = 8'h00;
endmodule

// File: tb/tb_tt_um_seven_segment_fun1.sv
// tb_tt_um_seven_segment_fun1: directed self-checking bench for the seven-segment counter
module tb_tt_um_seven_segment_fun1;
  localparam int DB = 8;
  localparam int AN = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;
  int checks = 0;
  int errors = 0;
  logic [6:0] hex [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  tt_um_seven_segment_fun1 #(.DEBOUNCE_CYCLES(DB), .ANIM_CYCLES(AN)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .ui_in(ui_in),
    .uo_out(uo_out),
    .uio_in(uio_in),
    .uio_out(uio_out),
    .uio_oe(uio_oe)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_btn(input int b);
    ui_in[b] = 1'b1;
    tick(16);
    ui_in[b] = 1'b0;
    tick(16);
  endtask
  task automatic wait_bit7(input logic v, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick(1);
      if (uo_out[7] === v) ok = 1'b1;
    end
  endtask
  task automatic test_reset;
    rst_n = 1'b1;
    tick(3);
    rst_n = 1'b0;
    tick(2);
    checks++; if (uo_out !== 8'h3F) begin errors++; $display("FAIL reset_uo_out got %h want 3f", uo_out); end
    checks++; if (uio_oe !== 8'h00) begin errors++; $display("FAIL reset_uio_oe got %h want 00", uio_oe); end
    checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL reset_uio_out got %h want 00", uio_out); end
  endtask
  task automatic test_glitch;
    ui_in[0] = 1'b1;
    tick(5);
    ui_in[0] = 1'b0;
    tick(15);
    checks++; if (uo_out !== 8'h3F) begin errors++; $display("FAIL glitch_ignored got %h want 3f", uo_out); end
    ui_in[0] = 1'b1;
    tick(20);
    checks++; if (uo_out !== 8'h06) begin errors++; $display("FAIL long_press got %h want 06", uo_out); end
    ui_in[0] = 1'b0;
    tick(20);
    checks++; if (uo_out !== 8'h06) begin errors++; $display("FAIL release_no_event got %h want 06", uo_out); end
  endtask
  task automatic test_dec_wrap;
    pulse_btn(3);
    checks++; if (uo_out !== 8'h3F) begin errors++; $display("FAIL clear got %h want 3f", uo_out); end
    pulse_btn(1);
    checks++; if (uo_out !== 8'h71) begin errors++; $display("FAIL dec_wrap got %h want 71", uo_out); end
    pulse_btn(0);
    checks++; if (uo_out !== 8'h3F) begin errors++; $display("FAIL inc_wrap got %h want 3f", uo_out); end
    pulse_btn(0);
    checks++; if (uo_out !== 8'h06) begin errors++; $display("FAIL inc_after_wrap got %h want 06", uo_out); end
  endtask
  task automatic test_hex_table;
    pulse_btn(3);
    for (int k = 0; k < 16; k++) begin
      checks++; if (uo_out !== {1'b0, hex[k]}) begin errors++; $display("FAIL hex_%0d got %h want %h", k, uo_out, {1'b0, hex[k]}); end
      pulse_btn(0);
    end
    checks++; if (uo_out !== 8'h3F) begin errors++; $display("FAIL hex_wrap got %h want 3f", uo_out); end
  endtask
  task automatic test_priority;
    repeat (5) pulse_btn(0);
    checks++; if (uo_out !== 8'h6D) begin errors++; $display("FAIL digit5 got %h want 6d", uo_out); end
    ui_in[0] = 1'b1;
    ui_in[3] = 1'b1;
    tick(16);
    ui_in = 8'h00;
    tick(16);
    checks++; if (uo_out !== 8'h3F) begin errors++; $display("FAIL clear_over_inc got %h want 3f", uo_out); end
    ui_in[0] = 1'b1;
    ui_in[1] = 1'b1;
    tick(16);
    ui_in = 8'h00;
    tick(16);
    checks++; if (uo_out !== 8'h06) begin errors++; $display("FAIL inc_over_dec got %h want 06", uo_out); end
  endtask
  task automatic test_mode;
    logic ok;
`ifdef SEVSEG_ANIM_EN
    ui_in[2] = 1'b1;
    wait_bit7(1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL anim_enter timeout got bit7 %b want 1", uo_out[7]); end
    checks++; if (uo_out !== 8'h81) begin errors++; $display("FAIL anim_start got %h want 81", uo_out); end
    tick(15);
    ui_in[2] = 1'b0;
    checks++; if (uo_out !== 8'h81) begin errors++; $display("FAIL anim_hold got %h want 81", uo_out); end
    tick(1);
    checks++; if (uo_out !== 8'h82) begin errors++; $display("FAIL anim_step1 got %h want 82", uo_out); end
    tick(4 * AN);
    checks++; if (uo_out !== 8'hA0) begin errors++; $display("FAIL anim_step5 got %h want a0", uo_out); end
    tick(AN);
    checks++; if (uo_out !== 8'h81) begin errors++; $display("FAIL anim_wrap got %h want 81", uo_out); end
    pulse_btn(0);
    ui_in[2] = 1'b1;
    wait_bit7(1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL anim_exit timeout got bit7 %b want 0", uo_out[7]); end
    checks++; if (uo_out !== 8'h5B) begin errors++; $display("FAIL anim_exit_digit got %h want 5b", uo_out); end
    ui_in[2] = 1'b0;
    tick(16);
    pulse_btn(2);
    checks++; if (uo_out[7] !== 1'b1) begin errors++; $display("FAIL anim_reenter got %b want 1", uo_out[7]); end
`else
    ok = 1'b1;
    pulse_btn(2);
    checks++; if (uo_out !== 8'h06 || !ok) begin errors++; $display("FAIL mode_ignored got %h want 06", uo_out); end
`endif
  endtask
  task automatic test_reset_mid;
    ui_in[0] = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    checks++; if (uo_out !== 8'h3F) begin errors++; $display("FAIL mid_reset got %h want 3f", uo_out); end
    rst_n = 1'b0;
    tick(DB + 1);
    checks++; if (uo_out !== 8'h3F) begin errors++; $display("FAIL held_no_early got %h want 3f", uo_out); end
    tick(1);
    checks++; if (uo_out !== 8'h06) begin errors++; $display("FAIL held_one_inc got %h want 06", uo_out); end
    tick(30);
    checks++; if (uo_out !== 8'h06) begin errors++; $display("FAIL held_single got %h want 06", uo_out); end
    ui_in[0] = 1'b0;
    tick(20);
    checks++; if (uo_out !== 8'h06) begin errors++; $display("FAIL held_release got %h want 06", uo_out); end
  endtask
  initial begin
    test_reset;
    test_glitch;
    test_dec_wrap;
    test_hex_table;
    test_priority;
    test_mode;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
